// File: rtl/lfsr_rand_gen.sv
// Fibonacci-LFSR random number generator with request/done handshake and
// rejection sampling against a runtime bound. `LFSR_SEED_LOAD_EN adds runtime reseeding.
module lfsr_rand_gen #(
  parameter int unsigned      WIDTH   = 14,
  parameter logic [WIDTH-1:0] TAPS    = 14'h3802,
  parameter logic [WIDTH-1:0] SEED    = 14'h30AF,
  parameter int unsigned      STEPS   = 1,
  parameter int unsigned      MAX_TRY = 15
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_RandNeed,
  input  logic [WIDTH-1:0] i_Bound,
`ifdef LFSR_SEED_LOAD_EN
  input  logic             i_SeedLoad,
  input  logic [WIDTH-1:0] i_Seed,
`endif
  output logic [WIDTH-1:0] o_RandNum,
  output logic             o_isRanDone,
  output logic             o_Busy,
  output logic             o_Fallback
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned TRY_W  = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
  localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRY - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == {WIDTH{1'b0}}) ?
                                          {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    lfsr_step = {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   bound_q, bound_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [TRY_W-1:0]   try_q, try_d;
  logic [WIDTH-1:0]   rand_q, rand_d;
  logic               fallback_q, fallback_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               seed_load_s;
  logic [WIDTH-1:0]   seed_val_s;
  logic               req_take_s;
  logic               accept_s;
  logic               try_last_s;

`ifdef LFSR_SEED_LOAD_EN
  assign seed_load_s = i_SeedLoad;
  assign seed_val_s  = (i_Seed == {WIDTH{1'b0}}) ? SEED_EFF : i_Seed;
`else
  assign seed_load_s = 1'b0;
  assign seed_val_s  = SEED_EFF;
`endif

  // A seed load in IDLE wins over a same-cycle request, which is dropped.
  assign req_take_s = i_RandNeed & ~seed_load_s;
  assign accept_s   = (bound_q == {WIDTH{1'b0}}) || (lfsr_q < bound_q);
  assign try_last_s = (try_q == TRY_LAST);

  // State and datapath registers
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_EFF;
      bound_q    <= {WIDTH{1'b0}};
      step_q     <= {STEP_W{1'b0}};
      try_q      <= {TRY_W{1'b0}};
      rand_q     <= {WIDTH{1'b0}};
      fallback_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      bound_q    <= bound_d;
      step_q     <= step_d;
      try_q      <= try_d;
      rand_q     <= rand_d;
      fallback_q <= fallback_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_take_s) state_d = S_SHIFT;
        else            state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (step_q == STEP_LAST) state_d = S_CHECK;
        else                     state_d = S_SHIFT;
      end
      S_CHECK: begin
        if (accept_s || try_last_s) state_d = S_DONE;
        else                        state_d = S_SHIFT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: LFSR, counters, latched bound and result
  always_comb begin
    logic [WIDTH-1:0] lfsr_nxt_s;
    lfsr_nxt_s = lfsr_q;
    bound_d    = bound_q;
    step_d     = step_q;
    try_d      = try_q;
    rand_d     = rand_q;
    fallback_d = fallback_q;
    case (state_q)
      S_IDLE: begin
        if (seed_load_s) begin
          lfsr_nxt_s = seed_val_s;
        end else if (i_RandNeed) begin
          bound_d = i_Bound;
          step_d  = {STEP_W{1'b0}};
          try_d   = {TRY_W{1'b0}};
        end else begin
          lfsr_nxt_s = lfsr_q;
        end
      end
      S_SHIFT: begin
        lfsr_nxt_s = lfsr_step(lfsr_q);
        if (step_q == STEP_LAST) step_d = {STEP_W{1'b0}};
        else                     step_d = step_q + STEP_W'(1);
      end
      S_CHECK: begin
        if (accept_s) begin
          rand_d     = lfsr_q;
          fallback_d = 1'b0;
        end else if (try_last_s) begin
          rand_d     = {WIDTH{1'b0}};
          fallback_d = 1'b1;
        end else begin
          try_d  = try_q + TRY_W'(1);
          step_d = {STEP_W{1'b0}};
        end
      end
      S_DONE:  lfsr_nxt_s = lfsr_q;
      default: lfsr_nxt_s = lfsr_q;
    endcase
    lfsr_d = (lfsr_q == {WIDTH{1'b0}}) ? SEED_EFF : lfsr_nxt_s;
  end

  // Output decode from next state so the handshake outputs come from flops
  always_comb begin
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  assign o_RandNum   = rand_q;
  assign o_isRanDone = done_q;
  assign o_Busy      = busy_q;
  assign o_Fallback  = fallback_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Self-checking bench for lfsr_rand_gen (default parameters): directed steps,
// expected results queued at request time and compared when done pulses.
module tb_lfsr_rand_gen;
  localparam int W       = 14;
  localparam int MAX_TRY = 15;
  localparam int STEPS   = 1;

  logic         clk = 1'b0;
  logic         i_Rst = 1'b1;
  logic         i_RandNeed = 1'b0;
  logic [W-1:0] i_Bound = 14'h0000;
`ifdef LFSR_SEED_LOAD_EN
  logic         i_SeedLoad = 1'b0;
  logic [W-1:0] i_Seed = 14'h0000;
`endif
  logic [W-1:0] o_RandNum;
  logic         o_isRanDone;
  logic         o_Busy;
  logic         o_Fallback;

  typedef struct {
    logic [W-1:0] val;
    logic         fb;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   exp_dones = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  lfsr_rand_gen dut (
    .i_Clk       (clk),
    .i_Rst       (i_Rst),
    .i_RandNeed  (i_RandNeed),
    .i_Bound     (i_Bound),
`ifdef LFSR_SEED_LOAD_EN
    .i_SeedLoad  (i_SeedLoad),
    .i_Seed      (i_Seed),
`endif
    .o_RandNum   (o_RandNum),
    .o_isRanDone (o_isRanDone),
    .o_Busy      (o_Busy),
    .o_Fallback  (o_Fallback)
  );

  function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
    logic fb;
    fb = ^(s & 14'h3802);
    return {s[W-2:0], fb};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    i_Rst = 1'b1;
    i_RandNeed = 1'b0;
    @(negedge clk);
    checks++; assert (o_RandNum === 14'h0000) else begin errors++; $error("FAIL rst_randnum obs=%h exp=0000", o_RandNum); end
    checks++; assert (o_isRanDone === 1'b0) else begin errors++; $error("FAIL rst_done obs=%b exp=0", o_isRanDone); end
    checks++; assert (o_Busy === 1'b0) else begin errors++; $error("FAIL rst_busy obs=%b exp=0", o_Busy); end
    checks++; assert (o_Fallback === 1'b0) else begin errors++; $error("FAIL rst_fallback obs=%b exp=0", o_Fallback); end
    i_Rst = 1'b0;
  endtask

  // One request; checks busy until done and the done latency in edges after acceptance.
  task automatic run_draw(input logic [W-1:0] bound, input logic [W-1:0] ev, input logic efb,
                          input int exp_lat, input int pulse_at, input string tag);
    int n;
    bit seen;
    exp_t e;
    @(negedge clk);
    i_RandNeed = 1'b1;
    i_Bound = bound;
    e.val = ev;
    e.fb = efb;
    sb_q.push_back(e);
    exp_dones++;
    n = 0;
    seen = 1'b0;
    while (!seen && n < exp_lat + 20) begin
      @(negedge clk);
      n++;
      if (n == 1) i_RandNeed = 1'b0;
      if (pulse_at > 0 && n == pulse_at) i_RandNeed = 1'b1;
      if (pulse_at > 0 && n == pulse_at + 1) i_RandNeed = 1'b0;
      checks++; assert (o_Busy === 1'b1) else begin errors++; $error("FAIL %s_busy cyc=%0d obs=%b exp=1", tag, n, o_Busy); end
      if (o_isRanDone === 1'b1) seen = 1'b1;
    end
    checks++; assert (seen && n == exp_lat + 1) else begin errors++; $error("FAIL %s_latency obs=%0d seen=%0b exp=%0d", tag, n, seen, exp_lat + 1); end
  endtask

  task automatic check_done_count(input string tag);
    checks++; assert (done_cnt === exp_dones) else begin errors++; $error("FAIL %s_donecount obs=%0d exp=%0d", tag, done_cnt, exp_dones); end
  endtask

  initial begin
    int d[3];
    int k;
    int n;
    logic [W-1:0] v;

    fork
      forever begin
        @(negedge clk);
        if (o_isRanDone === 1'b1) begin
          done_cnt++;
          checks++; assert (prev_done !== 1'b1) else begin errors++; $error("FAIL done_width obs=2+cycles exp=1"); end
          checks++; assert (sb_q.size() != 0) else begin errors++; $error("FAIL unexpected_done obs=%h exp=none", o_RandNum); end
          if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checks++; assert (o_RandNum === mon_e.val) else begin errors++; $error("FAIL randnum obs=%h exp=%h", o_RandNum, mon_e.val); end
            checks++; assert (o_Fallback === mon_e.fb) else begin errors++; $error("FAIL fallback obs=%b exp=%b", o_Fallback, mon_e.fb); end
          end
        end
        prev_done = o_isRanDone;
      end
    join_none

    // Reset state, then an unbounded draw
    do_reset();
    run_draw(14'h0000, 14'h215F, 1'b0, 2, 0, "unbounded");

    // First value rejected, second accepted
    do_reset();
    run_draw(14'h2000, 14'h02BE, 1'b0, 4, 0, "reject1");

    // Unreachable bound -> fallback; extra request pulsed while busy
    do_reset();
    run_draw(14'h0001, 14'h0000, 1'b1, 2 * MAX_TRY, 5, "fallback");
    repeat (8) @(negedge clk);
    check_done_count("busy_ignore");

    // Reset in the middle of a draw aborts it
    do_reset();
    @(negedge clk);
    i_RandNeed = 1'b1;
    i_Bound = 14'h0000;
    @(negedge clk);
    checks++; assert (o_Busy === 1'b1) else begin errors++; $error("FAIL abort_busy obs=%b exp=1", o_Busy); end
    #2 i_Rst = 1'b1;
    #1;
    checks++; assert (o_Busy === 1'b0) else begin errors++; $error("FAIL abort_rst_busy obs=%b exp=0", o_Busy); end
    checks++; assert (o_RandNum === 14'h0000) else begin errors++; $error("FAIL abort_rst_randnum obs=%h exp=0000", o_RandNum); end
    checks++; assert (o_isRanDone === 1'b0) else begin errors++; $error("FAIL abort_rst_done obs=%b exp=0", o_isRanDone); end
    @(negedge clk);
    i_Rst = 1'b0;
    i_RandNeed = 1'b0;
    repeat (6) @(negedge clk);
    check_done_count("abort");
    run_draw(14'h0000, 14'h215F, 1'b0, 2, 0, "after_abort");

    // Request held high: three back-to-back draws against the software model
    do_reset();
    v = 14'h30AF;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      v = model_step(v);
      e.val = v;
      e.fb = 1'b0;
      sb_q.push_back(e);
    end
    exp_dones += 3;
    @(negedge clk);
    i_RandNeed = 1'b1;
    i_Bound = 14'h0000;
    k = 0;
    n = 0;
    while (k < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (o_isRanDone === 1'b1) begin
        d[k] = n;
        k++;
        if (k == 3) i_RandNeed = 1'b0;
      end
    end
    i_RandNeed = 1'b0;
    checks++; assert (k === 3) else begin errors++; $error("FAIL b2b_count obs=%0d exp=3", k); end
    checks++; assert (d[0] === 3) else begin errors++; $error("FAIL b2b_first obs=%0d exp=3", d[0]); end
    checks++; assert (d[1] - d[0] === STEPS + 3) else begin errors++; $error("FAIL b2b_gap1 obs=%0d exp=%0d", d[1] - d[0], STEPS + 3); end
    checks++; assert (d[2] - d[1] === STEPS + 3) else begin errors++; $error("FAIL b2b_gap2 obs=%0d exp=%0d", d[2] - d[1], STEPS + 3); end
    repeat (8) @(negedge clk);
    check_done_count("b2b");

`ifdef LFSR_SEED_LOAD_EN
    // Zero seed load reloads SEED and drops the same-cycle request
    @(negedge clk);
    i_SeedLoad = 1'b1;
    i_Seed = 14'h0000;
    i_RandNeed = 1'b1;
    @(negedge clk);
    i_SeedLoad = 1'b0;
    i_RandNeed = 1'b0;
    checks++; assert (o_Busy === 1'b0) else begin errors++; $error("FAIL seedload_busy obs=%b exp=0", o_Busy); end
    repeat (6) @(negedge clk);
    check_done_count("seedload");
    run_draw(14'h0000, 14'h215F, 1'b0, 2, 0, "after_seedload");
`endif

    checks++; assert (sb_q.size() == 0) else begin errors++; $error("FAIL scoreboard_left obs=%0d exp=0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
